// File: rtl/string_hw_pkg.sv
// rtl/string_hw_pkg.sv - shared states, CSR map and accelerator register map for the string DMA sequencer
package string_hw_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_A,
    PUT_A,
    FETCH_B,
    PUT_B,
    GO,
    POLL,
    CLEAR,
    GET_R,
    STORE_R,
    FINISH
  } dma_state_t;

  // CPU-visible register offsets
  localparam logic [2:0] CSR_CTRL  = 3'd0;
  localparam logic [2:0] CSR_SRC_A = 3'd1;
  localparam logic [2:0] CSR_SRC_B = 3'd2;
  localparam logic [2:0] CSR_DST   = 3'd3;
  localparam logic [2:0] CSR_OP    = 3'd4;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_ERR    = 3;
  localparam int CTRL_IRQ_EN = 4;

  // Accelerator register map: control word, then operand A words, then operand B words
  localparam int ACC_CTRL     = 0;
  localparam int ACC_A_BASE   = 1;
  localparam int ACC_GO_BIT   = 1;
  localparam int ACC_DONE_BIT = 0;

  function automatic int acc_b_base(input int max_blocks);
    return ACC_A_BASE + max_blocks;
  endfunction

  // Number of 32-bit words moved per operand: ceil(len/4), never below 1, never above max_blocks
  function automatic logic [7:0] word_count(input logic [7:0] len, input int max_blocks);
    logic [7:0] words;
    words = 8'(({1'b0, len} + 9'd3) >> 2);
    if (words == 8'd0) begin
      words = 8'd1;
    end else if (int'(words) > max_blocks) begin
      words = 8'(max_blocks);
    end
    return words;
  endfunction

endpackage

// File: rtl/string_dma_csr.sv
// rtl/string_dma_csr.sv - CPU register block: control/status, operand addresses and operation word
module string_dma_csr
  import string_hw_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic        busy,
  input  logic        set_done,
  input  logic        set_err,
  output logic        start,
  output logic [31:0] src_a,
  output logic [31:0] src_b,
  output logic [31:0] dst,
  output logic [2:0]  op_index,
  output logic [7:0]  op_len,
  output logic        irq
);

  logic        done;
  logic        err;
  logic        irq_en;
  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic [31:0] rdata;

  assign wr      = s_chipselect & s_write;
  assign rd      = s_chipselect & s_read;
  assign ctrl_wr = wr & (s_address == CSR_CTRL);
  assign start   = ctrl_wr & s_writedata[CTRL_START] & ~busy;
  assign irq     = done & irq_en;

  // Sticky status bits; an engine set wins over a same-cycle write-1-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      err    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (set_done) begin
        done <= 1'b1;
      end else if (ctrl_wr && s_writedata[CTRL_DONE]) begin
        done <= 1'b0;
      end
      if (set_err) begin
        err <= 1'b1;
      end else if (ctrl_wr && s_writedata[CTRL_ERR]) begin
        err <= 1'b0;
      end
      if (ctrl_wr) begin
        irq_en <= s_writedata[CTRL_IRQ_EN];
      end
    end
  end

  // Operand registers are frozen while an operation is in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_a    <= '0;
      src_b    <= '0;
      dst      <= '0;
      op_index <= '0;
      op_len   <= '0;
    end else if (wr && !busy) begin
      case (s_address)
        CSR_SRC_A: src_a <= s_writedata;
        CSR_SRC_B: src_b <= s_writedata;
        CSR_DST:   dst   <= s_writedata;
        CSR_OP: begin
          op_index <= s_writedata[2:0];
          op_len   <= s_writedata[15:8];
        end
        default: ;
      endcase
    end
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    rdata = '0;
    case (s_address)
      CSR_CTRL: begin
        rdata[CTRL_BUSY]   = busy;
        rdata[CTRL_DONE]   = done;
        rdata[CTRL_ERR]    = err;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      CSR_SRC_A: rdata = src_a;
      CSR_SRC_B: rdata = src_b;
      CSR_DST:   rdata = dst;
      CSR_OP:    rdata = {16'b0, op_len, 5'b0, op_index};
      default:   rdata = '0;
    endcase
  end

  // Read data is registered and presented the cycle after the read strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= '0;
    end else if (rd) begin
      s_readdata <= rdata;
    end
  end

endmodule

// File: rtl/string_dma_sequencer.sv
// rtl/string_dma_sequencer.sv - moves string operands to an accelerator, runs it and stores the result
module string_dma_sequencer
  import string_hw_pkg::*;
#(
  parameter int MAX_BLOCKS   = 2,
  parameter int ADDRESS_BITS = 4,
  parameter int POLL_LIMIT   = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_chipselect,
  input  logic                    s_read,
  input  logic                    s_write,
  input  logic [2:0]              s_address,
  input  logic [31:0]             s_writedata,
  output logic [31:0]             s_readdata,
  output logic [31:0]             m_address,
  output logic                    m_read,
  output logic                    m_write,
  output logic [31:0]             m_writedata,
  input  logic [31:0]             m_readdata,
  input  logic                    m_waitrequest,
  output logic                    a_chipselect,
  output logic                    a_read,
  output logic                    a_write,
  output logic [ADDRESS_BITS:0]   a_address,
  output logic [31:0]             a_writedata,
  input  logic [31:0]             a_readdata,
  output logic                    irq
);

  localparam int AW     = ADDRESS_BITS + 1;
  localparam int PW     = (POLL_LIMIT > 0) ? $clog2(POLL_LIMIT + 1) : 1;
  localparam int B_BASE = acc_b_base(MAX_BLOCKS);

  dma_state_t  state;
  dma_state_t  state_next;
  logic [7:0]  cnt;
  logic        phase;
  logic [PW-1:0] poll_cnt;
  logic [31:0] data;
  logic        timed_out;

  logic        busy;
  logic        start;
  logic        set_done;
  logic        set_err;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] dst;
  logic [2:0]  op_index;
  logic [7:0]  op_len;

  logic [7:0]  nw;
  logic        last;
  logic        poll_at_limit;
  logic [31:0] word_offset;
  logic [31:0] go_word;
  logic [31:0] clear_word;

  assign busy          = (state != IDLE);
  assign nw            = word_count(op_len, MAX_BLOCKS);
  assign last          = (cnt == nw - 8'd1);
  assign poll_at_limit = (poll_cnt == PW'(POLL_LIMIT));
  assign word_offset   = {22'b0, cnt, 2'b00};
  assign go_word       = {19'b0, op_len, op_index, 1'b1, 1'b0};
  assign clear_word    = go_word & ~(32'd1 << ACC_GO_BIT);

  string_dma_csr u_csr (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .busy         (busy),
    .set_done     (set_done),
    .set_err      (set_err),
    .start        (start),
    .src_a        (src_a),
    .src_b        (src_b),
    .dst          (dst),
    .op_index     (op_index),
    .op_len       (op_len),
    .irq          (irq)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Word counter, poll counter, sub-phase and data holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      phase     <= 1'b0;
      poll_cnt  <= '0;
      data      <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            timed_out <= 1'b0;
          end
        end
        FETCH_A, FETCH_B: begin
          if (!m_waitrequest) begin
            data <= m_readdata;
          end
        end
        PUT_A, PUT_B: begin
          cnt <= last ? 8'd0 : cnt + 8'd1;
        end
        GO: begin
          poll_cnt <= '0;
          phase    <= 1'b0;
        end
        POLL: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (!a_readdata[ACC_DONE_BIT]) begin
              if (poll_at_limit) begin
                timed_out <= 1'b1;
              end else begin
                poll_cnt <= poll_cnt + 1'b1;
              end
            end
          end
        end
        CLEAR: begin
          cnt   <= '0;
          phase <= 1'b0;
        end
        GET_R: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            data  <= a_readdata;
          end
        end
        STORE_R: begin
          if (!m_waitrequest && !last) begin
            cnt <= cnt + 8'd1;
          end
        end
        FINISH: begin
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Next state and bus strobes; everything idles low outside its own state
  always_comb begin
    state_next   = state;
    m_address    = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = '0;
    a_chipselect = 1'b0;
    a_read       = 1'b0;
    a_write      = 1'b0;
    a_address    = '0;
    a_writedata  = '0;
    set_done     = 1'b0;
    set_err      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH_A;
        end
      end
      FETCH_A: begin
        m_read    = 1'b1;
        m_address = src_a + word_offset;
        if (!m_waitrequest) begin
          state_next = PUT_A;
        end
      end
      PUT_A: begin
        a_chipselect = 1'b1;
        a_write      = 1'b1;
        a_address    = AW'(ACC_A_BASE + int'(cnt));
        a_writedata  = data;
        if (!last) begin
          state_next = FETCH_A;
        end else if (op_index == 3'd0) begin
          state_next = FETCH_B;
        end else begin
          state_next = GO;
        end
      end
      FETCH_B: begin
        m_read    = 1'b1;
        m_address = src_b + word_offset;
        if (!m_waitrequest) begin
          state_next = PUT_B;
        end
      end
      PUT_B: begin
        a_chipselect = 1'b1;
        a_write      = 1'b1;
        a_address    = AW'(B_BASE + int'(cnt));
        a_writedata  = data;
        state_next   = last ? GO : FETCH_B;
      end
      GO: begin
        a_chipselect = 1'b1;
        a_write      = 1'b1;
        a_address    = AW'(ACC_CTRL);
        a_writedata  = go_word;
        state_next   = POLL;
      end
      POLL: begin
        if (!phase) begin
          a_chipselect = 1'b1;
          a_read       = 1'b1;
          a_address    = AW'(ACC_CTRL);
        end else if (a_readdata[ACC_DONE_BIT]) begin
          state_next = CLEAR;
        end else if (poll_at_limit) begin
          set_err    = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        a_chipselect = 1'b1;
        a_write      = 1'b1;
        a_address    = AW'(ACC_CTRL);
        a_writedata  = clear_word;
        state_next   = timed_out ? FINISH : GET_R;
      end
      GET_R: begin
        if (!phase) begin
          a_chipselect = 1'b1;
          a_read       = 1'b1;
          a_address    = AW'(ACC_A_BASE + int'(cnt));
        end else begin
          state_next = STORE_R;
        end
      end
      STORE_R: begin
        m_write     = 1'b1;
        m_address   = dst + word_offset;
        m_writedata = data;
        if (!m_waitrequest) begin
          state_next = last ? FINISH : GET_R;
        end
      end
      FINISH: begin
        set_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_string_dma_sequencer.sv
// tb/tb_string_dma_sequencer.sv - directed self-checking bench with memory and accelerator models
module tb_string_dma_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_chipselect, s_read, s_write;
  logic [2:0]  s_address;
  logic [31:0] s_writedata, s_readdata;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_waitrequest;
  logic        a_chipselect, a_read, a_write;
  logic [4:0]  a_address;
  logic [31:0] a_writedata;
  logic [31:0] a_readdata = '0;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  string_dma_sequencer #(.MAX_BLOCKS(2), .ADDRESS_BITS(4), .POLL_LIMIT(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_address(a_address), .a_writedata(a_writedata), .a_readdata(a_readdata),
    .irq(irq)
  );

  // Memory model with programmable wait states
  logic [31:0] mem [0:63];
  logic        clr = 1'b0;
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          fetch_cnt = 0, store_cnt = 0;

  assign m_waitrequest = (m_read | m_write) && (wcnt != wait_cfg);
  assign m_readdata    = mem[m_address[7:2]];

  always @(posedge clk) begin
    if (clr) begin
      fetch_cnt <= 0;
      store_cnt <= 0;
    end
    if (ld_en) mem[ld_addr] <= ld_data;
    if (m_read | m_write) wcnt <= (wcnt == wait_cfg) ? 0 : wcnt + 1;
    else wcnt <= 0;
    if (m_write && !m_waitrequest) begin
      mem[m_address[7:2]] <= m_writedata;
      store_cnt <= store_cnt + 1;
    end
    if (m_read && !m_waitrequest) fetch_cnt <= fetch_cnt + 1;
  end

  // Accelerator model: 0=compare A/B, 1=uppercase A, 2=lowercase A; done three cycles after go
  logic [31:0] areg [0:7];
  logic [31:0] go_word = '0, clear_word = '0;
  logic [2:0]  acnt = '0;
  logic        adone = 1'b0;
  logic        never_done = 1'b0;
  int          poll_seen = 0, b_writes = 0, go_seen = 0;

  function automatic logic [31:0] xform(input logic [31:0] w, input logic up);
    logic [31:0] r;
    logic [7:0]  b;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      if (up && b >= 8'h61 && b <= 8'h7a) b = b - 8'd32;
      else if (!up && b >= 8'h41 && b <= 8'h5a) b = b + 8'd32;
      r[8*k +: 8] = b;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      poll_seen <= 0;
      b_writes  <= 0;
      go_seen   <= 0;
    end
    if (a_read) begin
      a_readdata <= (a_address == 5'd0) ? {31'b0, adone} : areg[a_address[2:0]];
      if (a_address == 5'd0) poll_seen <= poll_seen + 1;
    end
    if (a_write) begin
      if (a_address == 5'd0) begin
        adone <= 1'b0;
        if (a_writedata[1]) begin
          go_word <= a_writedata;
          acnt    <= 3'd3;
          go_seen <= go_seen + 1;
        end else begin
          clear_word <= a_writedata;
        end
      end else begin
        areg[a_address[2:0]] <= a_writedata;
        if (a_address == 5'd3 || a_address == 5'd4) b_writes <= b_writes + 1;
      end
    end else if (acnt != 3'd0) begin
      acnt <= acnt - 3'd1;
      if (acnt == 3'd1 && !never_done) begin
        adone <= 1'b1;
        case (go_word[4:2])
          3'd0: begin
            areg[1] <= {31'b0, (areg[1] == areg[3]) && (areg[2] == areg[4])};
            areg[2] <= '0;
          end
          3'd1: begin
            areg[1] <= xform(areg[1], 1'b1);
            areg[2] <= xform(areg[2], 1'b1);
          end
          default: begin
            areg[1] <= xform(areg[1], 1'b0);
            areg[2] <= xform(areg[2], 1'b0);
          end
        endcase
      end
    end
  end

  // Bus protocol and activity monitor
  int viol = 0, act = 0;
  always @(negedge clk) begin
    if (clr) begin
      viol <= 0;
      act  <= 0;
    end else begin
      if ((m_read && m_write) || (a_read && a_write) || (a_chipselect != (a_read | a_write)))
        viol <= viol + 1;
      if (m_read | m_write | a_read | a_write | a_chipselect) act <= act + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_chipselect = 1'b0; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic mem_load(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_counts();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      csr_read(3'd0, d);
      if (d[2]) ok = 1'b1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic ok;
    int snap;
    reset_n = 1'b0;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
    s_address = '0; s_writedata = '0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {28'b0, m_read, m_write, a_read, a_write}, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_readdata", s_readdata, 32'h0);
    reset_n = 1'b1;
    csr_read(3'd0, rd);
    chk("reset_ctrl", rd, 32'h0);
    csr_read(3'd4, rd);
    chk("reset_op", rd, 32'h0);

    // Compare "abcdefgh" with "abcdefgh"
    mem_load(6'd0, 32'h64636261); mem_load(6'd1, 32'h68676665);
    mem_load(6'd4, 32'h64636261); mem_load(6'd5, 32'h68676665);
    mem_load(6'd8, 32'hffffffff); mem_load(6'd9, 32'hffffffff);
    csr_write(3'd1, 32'h00); csr_write(3'd2, 32'h10); csr_write(3'd3, 32'h20);
    csr_write(3'd4, 32'h0800);
    csr_read(3'd2, rd);
    chk("src_b_readback", rd, 32'h10);
    csr_write(3'd5, 32'h12345678);
    csr_read(3'd5, rd);
    chk("unmapped_reads_zero", rd, 32'h0);
    clear_counts();
    csr_write(3'd0, 32'h11);
    wait_done(ok);
    chk("cmp_done_seen", {31'b0, ok}, 32'h1);
    chk("cmp_dst0", mem[8], 32'h1);
    chk("cmp_dst1", mem[9], 32'h0);
    csr_read(3'd0, rd);
    chk("cmp_ctrl", rd, 32'h14);
    chk("cmp_irq", {31'b0, irq}, 32'h1);
    chk("cmp_fetches", fetch_cnt, 4);
    chk("cmp_b_writes", b_writes, 2);

    // Uppercase "AbCdEf  "
    csr_write(3'd0, 32'h04);
    csr_read(3'd0, rd);
    chk("w1c_done", rd, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    mem_load(6'd0, 32'h64436241); mem_load(6'd1, 32'h20206645);
    csr_write(3'd4, 32'h0801);
    clear_counts();
    csr_write(3'd0, 32'h01);
    wait_done(ok);
    chk("up_done_seen", {31'b0, ok}, 32'h1);
    chk("up_dst0", mem[8], 32'h44434241);
    chk("up_dst1", mem[9], 32'h20204645);
    chk("up_no_b_writes", b_writes, 0);
    chk("up_fetches", fetch_cnt, 2);
    chk("up_go_word", go_word, 32'h106);
    chk("up_clear_word", clear_word, 32'h104);

    // LEN=3 lowercase "ABC": single word each way
    csr_write(3'd0, 32'h04);
    mem_load(6'd0, 32'h00434241); mem_load(6'd9, 32'hdeadbeef);
    csr_write(3'd4, 32'h0302);
    clear_counts();
    csr_write(3'd0, 32'h01);
    wait_done(ok);
    chk("low_done_seen", {31'b0, ok}, 32'h1);
    chk("low_dst0", mem[8], 32'h00636261);
    chk("low_dst1_untouched", mem[9], 32'hdeadbeef);
    chk("low_fetches", fetch_cnt, 1);
    chk("low_stores", store_cnt, 1);
    chk("low_go_word", go_word, 32'h6a);

    // Accelerator never completes: poll timeout
    csr_write(3'd0, 32'h04);
    never_done = 1'b1;
    csr_write(3'd4, 32'h0401);
    clear_counts();
    csr_write(3'd0, 32'h01);
    wait_done(ok);
    chk("to_done_seen", {31'b0, ok}, 32'h1);
    chk("to_polls", poll_seen, 8);
    chk("to_stores", store_cnt, 0);
    csr_read(3'd0, rd);
    chk("to_ctrl", rd, 32'h0c);
    csr_write(3'd0, 32'h0c);
    csr_read(3'd0, rd);
    chk("to_ctrl_cleared", rd, 32'h0);

    // Five wait states per memory access, START and SRC_A write while busy
    never_done = 1'b0;
    wait_cfg = 5;
    mem_load(6'd0, 32'h64436241); mem_load(6'd1, 32'h20206645);
    mem_load(6'd8, 32'h0); mem_load(6'd9, 32'h0);
    csr_write(3'd4, 32'h0801);
    clear_counts();
    csr_write(3'd0, 32'h01);
    repeat (3) @(negedge clk);
    csr_write(3'd0, 32'h01);
    csr_write(3'd1, 32'h30);
    csr_read(3'd1, rd);
    chk("busy_src_write_ignored", rd, 32'h0);
    wait_done(ok);
    chk("ws_done_seen", {31'b0, ok}, 32'h1);
    chk("ws_dst0", mem[8], 32'h44434241);
    chk("ws_dst1", mem[9], 32'h20204645);
    chk("ws_fetches", fetch_cnt, 2);
    chk("ws_stores", store_cnt, 2);
    repeat (40) @(negedge clk);
    chk("ws_single_go", go_seen, 1);
    csr_read(3'd0, rd);
    chk("ws_ctrl_idle", rd, 32'h04);
    chk("protocol_violations", viol, 0);

    // Reset while polling
    wait_cfg = 0;
    never_done = 1'b1;
    csr_write(3'd0, 32'h14);
    clear_counts();
    csr_write(3'd0, 32'h01);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (poll_seen >= 2) ok = 1'b1;
    end
    chk("rst_reached_poll", {31'b0, ok}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_strobes", {27'b0, m_read, m_write, a_read, a_write, a_chipselect}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    snap = act;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_bus_activity", act, snap);
    csr_read(3'd0, rd);
    chk("rst_ctrl", rd, 32'h0);
    csr_read(3'd3, rd);
    chk("rst_dst", rd, 32'h0);
    csr_read(3'd4, rd);
    chk("rst_op", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/string_dma_sequencer.md
STRING_DMA_SEQUENCER -- requirements
Module: string_dma_sequencer

Interface
REQ-001 SHALL have parameter MAX_BLOCKS, default 2: maximum 32-bit string words per operand.
REQ-002 SHALL have parameter ADDRESS_BITS, default 4: accelerator address width is ADDRESS_BITS+1.
REQ-003 SHALL have parameter POLL_LIMIT, default 1023: done-poll reads before timeout.
REQ-004 SHALL have port clk  in  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have CSR slave ports from the CPU:
  - s_chipselect, s_read, s_write  in  1
  - s_address  in  3
  - s_writedata  in  32
  - s_readdata  out  32, registered, valid the cycle after s_read.
REQ-007 SHALL have memory master ports:
  - m_address  out  32, byte address
  - m_read, m_write  out  1
  - m_writedata  out  32
  - m_readdata  in  32
  - m_waitrequest  in  1
REQ-008 SHALL have accelerator master ports:
  - a_chipselect, a_read, a_write  out  1
  - a_address  out  ADDRESS_BITS+1
  - a_writedata  out  32
  - a_readdata  in  32
REQ-009 SHALL have port irq  out  1: DONE AND IRQ_EN.

Function
REQ-010 CSR map SHALL be:
  - 0 CTRL: bit0 START (write-1 pulse), bit1 BUSY (read-only), bit2 DONE (sticky, write-1-clear), bit3 ERR (sticky, write-1-clear), bit4 IRQ_EN (read/write).
  - 1 SRC_A, 2 SRC_B, 3 DST: read/write.
  - 4 OP: [2:0] INDEX, [15:8] LEN in bytes.
  - Addresses 5-7 SHALL read 0 and ignore writes.
REQ-011 Word count SHALL be NW = ceil(LEN/4), clamped to the range 1..MAX_BLOCKS; LEN=0 SHALL give NW=1.
REQ-012 FSM states SHALL be: IDLE, FETCH_A, PUT_A, FETCH_B, PUT_B, GO, POLL, CLEAR, GET_R, STORE_R, FINISH.
REQ-013 IDLE SHALL move to FETCH_A only on START=1 while BUSY=0; START while BUSY=1 SHALL be ignored.
REQ-014 FETCH_A/PUT_A for word i=0..NW-1:
  - FETCH_A: m_read at SRC_A+4i, held until m_waitrequest=0; data captured that cycle.
  - PUT_A: one-cycle a_write to a_address 1+i.
REQ-015 FETCH_B/PUT_B SHALL use SRC_B and a_address 3+i, and SHALL run only when INDEX=0; otherwise go straight from the A loop to GO.
REQ-016 GO SHALL do one a_write to address 0 with data {LEN[15:8] at [12:5], INDEX at [4:2], go=1 at [1], 0 at [0]}.
REQ-017 POLL SHALL repeat: a_read of address 0 for 1 cycle, sample a_readdata next cycle; exit to CLEAR when bit0=1.
REQ-018 After POLL_LIMIT+1 reads without done, POLL SHALL set ERR and go to CLEAR, skipping GET_R/STORE_R.
REQ-019 CLEAR SHALL write the GO data with bit1=0 to a_address 0.
REQ-020 GET_R/STORE_R for word i SHALL read a_address 1+i (1-cycle latency), then m_write to DST+4i, held until m_waitrequest=0.
REQ-021 FINISH SHALL set DONE, clear BUSY and return to IDLE in one cycle.
REQ-022 m_read and m_write SHALL never be high together; a_read and a_write SHALL never be high together; a_chipselect SHALL be high exactly when a_read or a_write is high.
REQ-023 A CPU write to SRC/DST/OP while BUSY=1 SHALL be ignored; CTRL write-1-clear SHALL always work.
REQ-024 Setting DONE and a CPU write-1-clear of DONE in the same cycle SHALL leave DONE set.

Reset
REQ-025 On reset_n=0, asynchronously:
  - FSM to IDLE.
  - All CSRs to 0.
  - Word and poll counters to 0.
  - All strobes and irq to 0; address/data outputs to 0.
REQ-026 Reset mid-operation SHALL abort without any further bus cycle; DONE=0 after reset.

Structure
REQ-027 The state enum, CSR offsets, CTRL bit positions and accelerator register offsets (CTRL=0, A=1, B=1+MAX_BLOCKS) SHALL live in package string_hw_pkg.
REQ-028 The CSR block SHALL be sub-module string_dma_csr; the FSM and datapath SHALL stay in the top module.

Verification
REQ-029 Scenario: mem SRC_A="abcdefgh", SRC_B="abcdefgh", INDEX=0, LEN=8 -> DST word0=1, DONE=1, irq=1 with IRQ_EN.
REQ-030 Scenario: SRC_A="AbCdEf  ", INDEX=1, LEN=8 -> DST="ABCDEF  "; no a_address 3/4 writes observed.
REQ-031 Scenario: LEN=3, INDEX=2, SRC_A="ABC" -> exactly one fetch and one store; DST word0="abc".
REQ-032 Scenario: accelerator model never sets done, POLL_LIMIT=7 -> exactly 8 polls, ERR=1, DONE=1, no m_write.
REQ-033 Scenario: m_waitrequest held 5 cycles per access, plus START while busy -> results unchanged, second START ignored.
REQ-034 Scenario: reset_n low during POLL -> all strobes 0 immediately; CSRs read 0.
